msrv32_machine_csr_file: RTL and testbench
==========================================

MSRV32_MACHINE_CSR_FILE -- requirements
Module: msrv32_machine_csr_file

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port csr_wr_en_in, input, 1 bit: a valid CSR instruction is in this stage.
REQ-004 SHALL have port csr_addr_in, input, 12 bits: CSR address.
REQ-005 SHALL have port csr_op_in, input, 3 bits: instruction funct3.
REQ-006 SHALL have port rs1_data_in, input, 32 bits: register operand.
REQ-007 SHALL have port imm_in, input, 5 bits: zimm operand.
REQ-008 SHALL have port pc_in, input, 32 bits: PC of the trapping instruction.
REQ-009 SHALL have port set_epc_in, input, 1 bit: load mepc.
REQ-010 SHALL have port set_cause_in, input, 1 bit: load mcause (trap taken).
REQ-011 SHALL have port cause_in, input, 4 bits: trap cause code.
REQ-012 SHALL have port i_or_e_in, input, 1 bit: 1 = interrupt, 0 = exception.
REQ-013 SHALL have port instret_inc_in, input, 1 bit: one instruction retired.
REQ-014 SHALL have port mie_clear_in, input, 1 bit: trap entry.
REQ-015 SHALL have port mie_set_in, input, 1 bit: mret.
REQ-016 SHALL have port irq_in, input, 3 bits: {e_irq, t_irq, s_irq}.
REQ-017 SHALL have port csr_data_out, output, 32 bits: old value of the addressed CSR.
REQ-018 SHALL have port illegal_csr_out, output, 1 bit: the access is illegal.
REQ-019 SHALL have ports mie_out, meie_out, mtie_out, msie_out, meip_out and mtip_out, output, 1 bit each: enable and pending bits for machine control.
REQ-020 SHALL have port trap_address_out, output, 32 bits: trap target PC.
REQ-021 SHALL have port epc_out, output, 32 bits: current mepc.

Function
REQ-022 SHALL implement this CSR map:
- mstatus 0x300: MIE = bit 3, MPIE = bit 7, MPP = bits 12:11, which always read 2'b11.
- misa 0x301: reads 0x4000_0100.
- mie 0x304: bits 11, 7 and 3.
- mtvec 0x305: base = bits 31:2, mode = bits 1:0, bit 1 forced 0.
- mscratch 0x340.
- mepc 0x341: bits 1:0 forced 0.
- mcause 0x342.
- mip 0x344: bits 11, 7 and 3.
- mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
- mhartid 0xF14: reads 0.
REQ-023 SHALL drive csr_data_out combinationally; an unmapped address reads 0.
REQ-024 SHALL decode csr_op_in as follows:
- 001/101: write.
- 010/110: set bits.
- 011/111: clear bits.
- 000/100: no write.
- The operand is imm_in zero-extended when csr_op_in[2]=1, else rs1_data_in.
REQ-025 SHALL NOT write for a set or clear whose operand is 0.
REQ-026 SHALL make a write visible on the read path from the next cycle; writes to misa and to read-only bits SHALL be ignored.
REQ-027 SHALL assert illegal_csr_out combinationally when csr_wr_en_in=1 and either condition holds:
- the address is unmapped;
- a write is attempted to an address with addr[11:10]=2'b11.
REQ-028 SHALL perform no write on an illegal access.
REQ-029 SHALL register mip bits {11, 7, 3} from irq_in every cycle, giving 1-cycle latency; CSR writes to mip SHALL be ignored.
REQ-030 On set_epc_in SHALL load mepc <= {pc_in[31:2], 2'b00}.
REQ-031 On set_cause_in SHALL load mcause <= {i_or_e_in, 27'b0, cause_in}.
REQ-032 On mie_clear_in SHALL load MPIE <= MIE and MIE <= 0.
REQ-033 On mie_set_in SHALL load MIE <= MPIE and MPIE <= 1; if mie_clear_in and mie_set_in are both high, mie_clear_in SHALL win.
REQ-034 SHALL suppress the entire CSR write in any cycle where set_epc_in, set_cause_in or mie_clear_in is high (the instruction is flushed).
REQ-035 SHALL increment the 64-bit mcycle every cycle.
REQ-036 SHALL increment the 64-bit minstret when instret_inc_in=1.
REQ-037 SHALL wrap both counters from 0xFFFF_FFFF_FFFF_FFFF to 0, with carry from the low half into the high half.
REQ-038 SHALL let a CSR write to either half of a counter replace that half and suppress that counter's increment in that cycle.
REQ-039 SHALL drive trap_address_out combinationally:
- {base, 2'b00} + 4*cause_in when mode=01 and i_or_e_in=1;
- {base, 2'b00} otherwise.
REQ-040 SHALL drive epc_out and the enable/pending outputs directly from their registers.

Reset
REQ-041 While reset_n_in=0, all registers and counters SHALL be 0, so every registered output reads 0 (mstatus reads 0x0000_1800).
REQ-042 Assertion of reset_n_in mid-operation SHALL take effect immediately and discard any in-flight write; counting SHALL resume from 0 on the first edge after release.

Verification
REQ-043 Reset release, then read 0xB00 on 4 consecutive cycles -> 0, 1, 2, 3.
REQ-044 CSRRW 0x305 with rs1=0x0000_1003 -> read 0x0000_1001; with i_or_e_in=1, cause_in=7 -> trap_address_out=0x0000_101C; with i_or_e_in=0 -> 0x0000_1000.
REQ-045 CSRRSI 0x300 with imm=8 -> 0x1808; then mie_clear_in -> 0x1880 and mie_out=0; then mie_set_in -> 0x1888.
REQ-046 set_epc_in with pc_in=0x206, plus set_cause_in with cause_in=2 and i_or_e_in=0, plus a simultaneous CSRRW 0x341 with rs1=0x500 -> mepc=0x204, mcause=2, write dropped.
REQ-047 CSRRW 0xFFFF_FFFF to 0xB02 and 0xB82, then instret_inc_in pulse -> minstret and minstreth read 0.
REQ-048 Illegal accesses:
- Access 0x7C0 -> illegal_csr_out=1, data 0.
- CSRRS 0xF14 with rs1=0 -> illegal_csr_out=0.
- CSRRS 0xF14 with rs1=1 -> illegal_csr_out=1.

Source files
------------

// File: rtl/msrv32_machine_csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, trap state, mip sampling and 64-bit counters.
// Latency: reads and trap address are combinational; writes and trap updates land on the next clk_in edge.
// Backpressure: none; every access completes in a single cycle, and trap/flush inputs drop the CSR write.
//
// Ports:
//   clk_in, reset_n_in              clock and asynchronous active-low reset
//   csr_wr_en_in, csr_addr_in,
//   csr_op_in, rs1_data_in, imm_in  CSR instruction (funct3 selects write/set/clear and the operand source)
//   pc_in, set_epc_in, set_cause_in,
//   cause_in, i_or_e_in             trap entry: load mepc and mcause
//   mie_clear_in, mie_set_in        trap entry / mret handling of MIE and MPIE
//   instret_inc_in                  retire pulse for minstret
//   irq_in                          {external, timer, software} interrupt lines, sampled into mip
//   csr_data_out, illegal_csr_out   old CSR value and illegal-access flag
//   mie/meie/mtie/msie/meip/mtip_out enable and pending bits
//   trap_address_out, epc_out       trap target PC and current mepc
module msrv32_machine_csr_file (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        csr_wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [31:0] rs1_data_in,
  input  logic [4:0]  imm_in,
  input  logic [31:0] pc_in,
  input  logic        set_epc_in,
  input  logic        set_cause_in,
  input  logic [3:0]  cause_in,
  input  logic        i_or_e_in,
  input  logic        instret_inc_in,
  input  logic        mie_clear_in,
  input  logic        mie_set_in,
  input  logic [2:0]  irq_in,
  output logic [31:0] csr_data_out,
  output logic        illegal_csr_out,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        msie_out,
  output logic        meip_out,
  output logic        mtip_out,
  output logic [31:0] trap_address_out,
  output logic [31:0] epc_out
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        meie_q, meie_d;
  logic        mtie_q, mtie_d;
  logic        msie_q, msie_d;
  logic [31:0] mtvec_q, mtvec_d;       // bit 1 held at 0, bit 0 is the vectored-mode flag
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;         // bits 1:0 held at 0
  logic [31:0] mcause_q, mcause_d;
  logic        meip_q, meip_d;
  logic        mtip_q, mtip_d;
  logic        msip_q, msip_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        addr_mapped;
  logic [31:0] rd_data;
  logic [31:0] operand;
  logic        wr_attempt;
  logic        flush;
  logic        csr_we;
  logic [31:0] wr_data;

  // Read path: old value of the addressed CSR, 0 when unmapped.
  always_comb begin
    rd_data     = 32'h0;
    addr_mapped = 1'b1;
    case (csr_addr_in)
      ADDR_MSTATUS:   rd_data = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      ADDR_MISA:      rd_data = MISA_VALUE;
      ADDR_MIE:       rd_data = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
      ADDR_MTVEC:     rd_data = mtvec_q;
      ADDR_MSCRATCH:  rd_data = mscratch_q;
      ADDR_MEPC:      rd_data = mepc_q;
      ADDR_MCAUSE:    rd_data = mcause_q;
      ADDR_MIP:       rd_data = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
      ADDR_MCYCLE:    rd_data = mcycle_q[31:0];
      ADDR_MCYCLEH:   rd_data = mcycle_q[63:32];
      ADDR_MINSTRET:  rd_data = minstret_q[31:0];
      ADDR_MINSTRETH: rd_data = minstret_q[63:32];
      ADDR_MHARTID:   rd_data = 32'h0;
      default:        addr_mapped = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so it neither writes nor
  // counts as a write attempt to a read-only address.
  always_comb begin
    operand    = csr_op_in[2] ? {27'b0, imm_in} : rs1_data_in;
    wr_attempt = (csr_op_in[1:0] == 2'b01) || (csr_op_in[1] && (operand != 32'h0));
    case (csr_op_in[1:0])
      2'b10:   wr_data = rd_data | operand;
      2'b11:   wr_data = rd_data & ~operand;
      default: wr_data = operand;
    endcase
  end

  assign illegal_csr_out = csr_wr_en_in &&
                           (!addr_mapped || (wr_attempt && (csr_addr_in[11:10] == 2'b11)));
  // Any trap-side event in the same cycle means the CSR instruction is being flushed.
  assign flush  = set_epc_in || set_cause_in || mie_clear_in;
  assign csr_we = csr_wr_en_in && wr_attempt && !illegal_csr_out && !flush;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    meie_d         = meie_q;
    mtie_d         = mtie_q;
    msie_d         = msie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'b0, instret_inc_in};

    if (csr_we) begin
      case (csr_addr_in)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wr_data[3];
          mstatus_mpie_d = wr_data[7];
        end
        ADDR_MIE: begin
          meie_d = wr_data[11];
          mtie_d = wr_data[7];
          msie_d = wr_data[3];
        end
        ADDR_MTVEC:     mtvec_d    = wr_data & 32'hFFFF_FFFD;
        ADDR_MSCRATCH:  mscratch_d = wr_data;
        ADDR_MEPC:      mepc_d     = wr_data & 32'hFFFF_FFFC;
        ADDR_MCAUSE:    mcause_d   = wr_data;
        // Writing one half replaces it and freezes the whole counter for this cycle.
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wr_data};
        ADDR_MCYCLEH:   mcycle_d   = {wr_data, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], wr_data};
        ADDR_MINSTRETH: minstret_d = {wr_data, minstret_q[31:0]};
        default: ;  // misa, mip and mhartid ignore writes
      endcase
    end

    if (set_epc_in) begin
      mepc_d = pc_in & 32'hFFFF_FFFC;
    end
    if (set_cause_in) begin
      mcause_d = {i_or_e_in, 27'b0, cause_in};
    end
    // Trap entry wins over mret when both are signalled.
    if (mie_clear_in) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mie_set_in) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    meip_d = irq_in[2];
    mtip_d = irq_in[1];
    msip_d = irq_in[0];
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      meie_q         <= 1'b0;
      mtie_q         <= 1'b0;
      msie_q         <= 1'b0;
      mtvec_q        <= 32'h0;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      meip_q         <= 1'b0;
      mtip_q         <= 1'b0;
      msip_q         <= 1'b0;
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      meie_q         <= meie_d;
      mtie_q         <= mtie_d;
      msie_q         <= msie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      meip_q         <= meip_d;
      mtip_q         <= mtip_d;
      msip_q         <= msip_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  // Vectored mode offsets only interrupts; exceptions always go to the base.
  always_comb begin
    trap_address_out = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && i_or_e_in) begin
      trap_address_out = {mtvec_q[31:2], 2'b00} + {26'b0, cause_in, 2'b00};
    end
  end

  assign csr_data_out = rd_data;
  assign epc_out      = mepc_q;
  assign mie_out      = mstatus_mie_q;
  assign meie_out     = meie_q;
  assign mtie_out     = mtie_q;
  assign msie_out     = msie_q;
  assign meip_out     = meip_q;
  assign mtip_out     = mtip_q;

endmodule

// File: tb/tb_msrv32_machine_csr_file.sv
// Bench for msrv32_machine_csr_file: directed scenarios then randomized traffic against a word-level model.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later, model advanced on the rising edge.
// Backpressure: none; every cycle carries one access.
module tb_msrv32_machine_csr_file;

  logic        clk_in;
  logic        reset_n_in;
  logic        csr_wr_en_in;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic [31:0] rs1_data_in;
  logic [4:0]  imm_in;
  logic [31:0] pc_in;
  logic        set_epc_in;
  logic        set_cause_in;
  logic [3:0]  cause_in;
  logic        i_or_e_in;
  logic        instret_inc_in;
  logic        mie_clear_in;
  logic        mie_set_in;
  logic [2:0]  irq_in;
  logic [31:0] csr_data_out;
  logic        illegal_csr_out;
  logic        mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out;
  logic [31:0] trap_address_out;
  logic [31:0] epc_out;

  msrv32_machine_csr_file dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .csr_wr_en_in(csr_wr_en_in), .csr_addr_in(csr_addr_in), .csr_op_in(csr_op_in),
    .rs1_data_in(rs1_data_in), .imm_in(imm_in), .pc_in(pc_in),
    .set_epc_in(set_epc_in), .set_cause_in(set_cause_in), .cause_in(cause_in),
    .i_or_e_in(i_or_e_in), .instret_inc_in(instret_inc_in),
    .mie_clear_in(mie_clear_in), .mie_set_in(mie_set_in), .irq_in(irq_in),
    .csr_data_out(csr_data_out), .illegal_csr_out(illegal_csr_out),
    .mie_out(mie_out), .meie_out(meie_out), .mtie_out(mtie_out), .msie_out(msie_out),
    .meip_out(meip_out), .mtip_out(mtip_out),
    .trap_address_out(trap_address_out), .epc_out(epc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests_run;
  int tests_failed;

  // Architectural view: each CSR kept as the 32-bit word software would read.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_cycle, m_inst;
  logic [11:0] addr_tbl [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mstatus = 32'h0000_1800;
    m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mip = 0;
    m_cycle = 0; m_inst = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_inst[31:0];
      12'hB82: return m_inst[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_mapped(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_operand();
    return csr_op_in[2] ? {27'b0, imm_in} : rs1_data_in;
  endfunction

  function automatic bit m_attempt();
    if (csr_op_in[1:0] == 2'b00) return 1'b0;
    if (csr_op_in[1:0] == 2'b01) return 1'b1;
    return m_operand() != 32'h0;
  endfunction

  function automatic bit m_illegal();
    return csr_wr_en_in && (!m_mapped(csr_addr_in) ||
           (m_attempt() && csr_addr_in[11:10] == 2'b11));
  endfunction

  task automatic compare_model(input string tag);
    logic [31:0] exp_trap;
    exp_trap = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[0] && i_or_e_in) exp_trap = exp_trap + 32'(cause_in) * 32'd4;
    check({tag, ".data"}, csr_data_out, m_read(csr_addr_in));
    check({tag, ".illegal"}, {31'b0, illegal_csr_out}, {31'b0, m_illegal()});
    check({tag, ".trap"}, trap_address_out, exp_trap);
    check({tag, ".epc"}, epc_out, m_mepc);
    check({tag, ".flags"},
          {26'b0, mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out},
          {26'b0, m_mstatus[3], m_mie[11], m_mie[7], m_mie[3], m_mip[11], m_mip[7]});
  endtask

  // Applies the architectural rules for one rising edge using the current inputs.
  task automatic model_step();
    logic [31:0] opnd, old, nv, st_old;
    logic [63:0] nc, ni;
    bit wr;
    opnd = m_operand();
    old  = m_read(csr_addr_in);
    wr   = csr_wr_en_in && m_attempt() && !m_illegal() &&
           !(set_epc_in || set_cause_in || mie_clear_in);
    case (csr_op_in[1:0])
      2'b10:   nv = old | opnd;
      2'b11:   nv = old & ~opnd;
      default: nv = opnd;
    endcase
    st_old = m_mstatus;
    nc = m_cycle + 64'd1;
    ni = m_inst + (instret_inc_in ? 64'd1 : 64'd0);
    if (wr) begin
      case (csr_addr_in)
        12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
        12'h304: m_mie      = nv & 32'h888;
        12'h305: m_mtvec    = nv & ~32'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'hB00: nc = {m_cycle[63:32], nv};
        12'hB80: nc = {nv, m_cycle[31:0]};
        12'hB02: ni = {m_inst[63:32], nv};
        12'hB82: ni = {nv, m_inst[31:0]};
        default: ;
      endcase
    end
    if (set_epc_in)   m_mepc   = pc_in & ~32'h3;
    if (set_cause_in) m_mcause = (i_or_e_in ? 32'h8000_0000 : 32'h0) | 32'(cause_in);
    if (mie_clear_in)    m_mstatus = 32'h1800 | (st_old[3] ? 32'h80 : 32'h0);
    else if (mie_set_in) m_mstatus = 32'h1880 | (st_old[7] ? 32'h8 : 32'h0);
    m_mip = (irq_in[2] ? 32'h800 : 32'h0) | (irq_in[1] ? 32'h80 : 32'h0) |
            (irq_in[0] ? 32'h8 : 32'h0);
    m_cycle = nc;
    m_inst  = ni;
  endtask

  task automatic idle();
    csr_wr_en_in = 0; csr_addr_in = 12'h0; csr_op_in = 3'b000; rs1_data_in = 0; imm_in = 0;
    pc_in = 0; set_epc_in = 0; set_cause_in = 0; cause_in = 0; i_or_e_in = 0;
    instret_inc_in = 0; mie_clear_in = 0; mie_set_in = 0; irq_in = 0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [2:0] op,
                     input logic [31:0] rs1, input logic [4:0] imm);
    csr_wr_en_in = 1; csr_addr_in = a; csr_op_in = op; rs1_data_in = rs1; imm_in = imm;
  endtask

  task automatic rd(input logic [11:0] a);
    idle();
    csr_addr_in = a;
  endtask

  task automatic step(input string tag);
    #1;
    compare_model(tag);
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  // Asserts reset between clock edges, checks it acted at once, releases on a falling edge.
  task automatic do_reset(input logic [31:0] exp_data);
    reset_n_in = 1'b0;
    #1;
    model_reset();
    check("reset.data", csr_data_out, exp_data);
    compare_model("reset");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    addr_tbl[0] = 12'h300; addr_tbl[1] = 12'h301; addr_tbl[2] = 12'h304; addr_tbl[3] = 12'h305;
    addr_tbl[4] = 12'h340; addr_tbl[5] = 12'h341; addr_tbl[6] = 12'h342; addr_tbl[7] = 12'h344;
    addr_tbl[8] = 12'hB00; addr_tbl[9] = 12'hB80; addr_tbl[10] = 12'hB02; addr_tbl[11] = 12'hB82;
    addr_tbl[12] = 12'hF14; addr_tbl[13] = 12'h7C0; addr_tbl[14] = 12'hF11; addr_tbl[15] = 12'hB01;
    idle();
    csr_addr_in = 12'h300;
    reset_n_in = 1'b1;
    #2;
    do_reset(32'h0000_1800);

    // mcycle counts 0,1,2,3 from release
    rd(12'hB00);
    for (int i = 0; i < 4; i++) begin
      #1 check("mcycle_seq", csr_data_out, 32'(i));
      step("mcycle_seq");
    end

    // mtvec vectored mode
    csr(12'h305, 3'b001, 32'h0000_1003, 5'd0); step("mtvec_wr");
    rd(12'h305); i_or_e_in = 1; cause_in = 4'd7;
    #1 check("mtvec_rd", csr_data_out, 32'h0000_1001);
    check("trap_vec", trap_address_out, 32'h0000_101C);
    step("trap_vec");
    rd(12'h305); i_or_e_in = 0; cause_in = 4'd7;
    #1 check("trap_exc", trap_address_out, 32'h0000_1000);
    step("trap_exc");

    // mstatus MIE/MPIE stacking
    csr(12'h300, 3'b110, 32'h0, 5'd8); step("csrrsi");
    rd(12'h300); #1 check("mstatus_set", csr_data_out, 32'h0000_1808); step("mstatus_set");
    idle(); mie_clear_in = 1; step("mie_clear");
    rd(12'h300); #1 check("mstatus_clr", csr_data_out, 32'h0000_1880);
    check("mie_out_clr", {31'b0, mie_out}, 32'h0); step("mstatus_clr");
    idle(); mie_set_in = 1; step("mie_set");
    rd(12'h300); #1 check("mstatus_mret", csr_data_out, 32'h0000_1888); step("mstatus_mret");

    // trap entry flushes a concurrent CSR write
    csr(12'h341, 3'b001, 32'h500, 5'd0);
    set_epc_in = 1; pc_in = 32'h206; set_cause_in = 1; cause_in = 4'd2; i_or_e_in = 0;
    step("trap_flush");
    rd(12'h341); #1 check("mepc", csr_data_out, 32'h204); check("epc_out", epc_out, 32'h204);
    step("mepc");
    rd(12'h342); #1 check("mcause", csr_data_out, 32'h2); step("mcause");

    // minstret full wrap
    csr(12'hB02, 3'b001, 32'hFFFF_FFFF, 5'd0); step("minstret_lo");
    csr(12'hB82, 3'b001, 32'hFFFF_FFFF, 5'd0); step("minstret_hi");
    idle(); instret_inc_in = 1; step("instret_pulse");
    rd(12'hB02); #1 check("minstret_wrap", csr_data_out, 32'h0); step("minstret_wrap");
    rd(12'hB82); #1 check("minstreth_wrap", csr_data_out, 32'h0); step("minstreth_wrap");

    // mcycle full wrap
    csr(12'hB80, 3'b001, 32'hFFFF_FFFF, 5'd0); step("mcycle_hi");
    csr(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0); step("mcycle_lo");
    rd(12'hB00); #1 check("mcycle_full", csr_data_out, 32'hFFFF_FFFF); step("mcycle_full");
    rd(12'hB80); #1 check("mcycleh_wrap", csr_data_out, 32'h0); step("mcycleh_wrap");

    // illegal accesses
    csr(12'h7C0, 3'b010, 32'h0, 5'd0);
    #1 check("ill_unmapped", {31'b0, illegal_csr_out}, 32'h1);
    check("ill_unmapped_data", csr_data_out, 32'h0); step("ill_unmapped");
    csr(12'hF14, 3'b010, 32'h0, 5'd0);
    #1 check("hartid_read", {31'b0, illegal_csr_out}, 32'h0); step("hartid_read");
    csr(12'hF14, 3'b010, 32'h1, 5'd0);
    #1 check("hartid_set", {31'b0, illegal_csr_out}, 32'h1); step("hartid_set");

    // mid-operation reset discards the in-flight write
    csr(12'h340, 3'b001, 32'h1234, 5'd0); step("mscratch_wr");
    csr(12'h340, 3'b001, 32'hDEAD_BEEF, 5'd0);
    #1 check("mscratch_old", csr_data_out, 32'h1234);
    do_reset(32'h0);
    rd(12'h340); step("post_reset_scratch");
    rd(12'hB00); #1 check("post_reset_cnt", csr_data_out, 32'h1); step("post_reset_cnt");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      csr_wr_en_in   = 1'($urandom_range(0, 3) != 0);
      csr_addr_in    = addr_tbl[$urandom_range(0, 15)];
      csr_op_in      = 3'($urandom);
      rs1_data_in    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      imm_in         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      pc_in          = $urandom;
      set_epc_in     = 1'($urandom_range(0, 7) == 0);
      set_cause_in   = 1'($urandom_range(0, 7) == 0);
      cause_in       = 4'($urandom);
      i_or_e_in      = 1'($urandom);
      instret_inc_in = 1'($urandom);
      mie_clear_in   = 1'($urandom_range(0, 7) == 0);
      mie_set_in     = 1'($urandom_range(0, 5) == 0);
      irq_in         = 3'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
